if_fetch_controller: RTL and testbench
======================================

// Module: if_fetch_controller
// PURPOSE
//   Sequences the IF stage: owns the PC, drives instruction-memory requests with a ready handshake,
//   resolves branch/jump redirects, honours hazard stalls and loads the IF/ID pipeline register.
//   Replaces free-running PC update logic; sits between hazard unit, EX/MEM branch result, ID jump decode and imem.
// PARAMETERS
//   ADDR_W    32            PC / address width (word-addressed, PC increments by 1)
//   RESET_PC  32'h0000_0000 PC value after reset
//   NOP_INSN  32'h0000_0000 encoding loaded into IF_ID_IR on squash/reset
// PORTS
//   clk               in   1       rising-edge clock
//   rst_n             in   1       synchronous reset, active low
//   stall             in   1       hazard unit: hold IF/ID and PC
//   branch            in   1       EX/MEM branch taken
//   EXMEM_AddResult   in   ADDR_W  branch target
//   jump              in   1       ID-stage jump
//   jump_destination  in   ADDR_W  jump target
//   imem_req          out  1       fetch request valid
//   imem_addr         out  ADDR_W  fetch address (= pc)
//   imem_ready        in   1       imem_rdata valid this cycle for imem_addr
//   imem_rdata        in   32      fetched instruction
//   IF_ID_IR          out  32      IF/ID instruction register
//   IF_ID_NPC         out  ADDR_W  IF/ID next-PC register (fetch pc + 1)
//   IF_ID_valid       out  1       IF/ID holds a real instruction
//   flush_id          out  1       one-cycle pulse: kill instruction in ID (redirect taken)
//   pc                out  ADDR_W  current PC (debug)
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): pc=RESET_PC, IF_ID_IR=NOP_INSN, IF_ID_NPC=0, IF_ID_valid=0,
//     flush_id=0, pend_valid=0, state=S_FETCH. imem_req=0 while rst_n=0; reset mid-wait discards the access.
//   Redirect: redir = branch | jump; target = branch ? EXMEM_AddResult : jump_destination
//     (branch wins: older instruction). Redirect beats stall in every state.
//   imem_addr = pc always; imem_req = 1 in S_FETCH/S_WAIT, 0 in S_STALL.
//   FSM:
//     S_FETCH: imem_ready=1 & redir        -> pc<=target, IR<=NOP, valid<=0, flush_id<=1, stay.
//              imem_ready=1 & stall        -> drop rdata, IF/ID and pc held, -> S_STALL.
//              imem_ready=1 else           -> IR<=rdata, NPC<=pc+1, valid<=1, pc<=pc+1, stay.
//              imem_ready=0                -> -> S_WAIT; if redir: pend_valid<=1, pend_tgt<=target, flush_id<=1.
//     S_WAIT:  imem_ready=0                -> hold; new redir overwrites pend_tgt, flush_id<=1.
//              imem_ready=1                -> priority: redir this cycle, else pend_valid (pc<=pend_tgt,
//                                             IR<=NOP, valid<=0), else stall (-> S_STALL), else normal load;
//                                             pend_valid<=0, -> S_FETCH (S_STALL if stalled).
//     S_STALL: redir -> pc<=target, IR<=NOP, valid<=0, flush_id<=1, -> S_FETCH;
//              stall=0 -> S_FETCH (refetch same pc); else hold.
//   flush_id: registered, asserted exactly the cycle after each redirect is accepted, else 0.
//   IF_ID_* hold value whenever not explicitly loaded (stall or wait never corrupts them).
//   Latency: imem_ready tied 1, no stall -> one instruction per cycle; IR valid the edge after pc issued.
//   Arithmetic: pc+1 modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0, no flag).
//   Simultaneous branch & jump: branch target taken, single flush_id pulse.
// STRUCTURE
//   Shared package (cpu_pkg): state encoding S_FETCH/S_WAIT/S_STALL, NOP_INSN, ADDR_W default.
//   Sub-module: if_redirect_sel (combinational branch/jump priority -> redir, target). Rest flat.
// TESTING
//   Reset, ready=1, 5 cycles -> IR=mem[0..3] in sequence, NPC=1,2,3,4, valid=1, flush_id=0.
//   branch=1 target=0x20 at pc=5 -> next pc=0x20, IR=NOP, valid=0, flush_id=1 one cycle; then mem[0x20].
//   branch=1 (0x40) & jump=1 (0x80) same cycle -> pc=0x40, one flush_id pulse.
//   stall=1 for 3 cycles at pc=7 -> IR/NPC frozen, imem_req=0; stall=0 -> fetch pc=7, IR=mem[7].
//   ready=0 for 4 cycles, jump (0x10) in cycle 2 -> on ready rdata dropped, pc=0x10, valid=0.
//   pc=2^ADDR_W-1 sequential fetch -> NPC=0, pc wraps to 0; rst_n=0 during S_WAIT -> pc=RESET_PC, valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared IF-stage types and defaults
// Purpose: fetch FSM state encoding plus default address width and NOP encoding.
// Ports: none (package).
package cpu_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_redirect_sel.sv
// rtl/if_redirect_sel.sv - branch/jump redirect priority select
// Purpose: merges the EX/MEM branch and ID jump into one redirect request.
// Ports:
//   branch, branch_target : EX/MEM branch taken and its target
//   jump, jump_target     : ID-stage jump and its target
//   redir, target         : combined redirect request and chosen target
module if_redirect_sel
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              redir,
  output logic [ADDR_W-1:0] target
);

  // The branch belongs to the older instruction, so it overrides a younger jump.
  assign redir  = branch | jump;
  assign target = branch ? branch_target : jump_target;

endmodule

// File: rtl/if_fetch_controller.sv
// rtl/if_fetch_controller.sv - IF stage PC / imem handshake / IF-ID register sequencer
// Purpose: owns the PC, issues imem requests, applies redirects and stalls, loads IF/ID.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   stall                              : hazard unit hold request
//   branch, EXMEM_AddResult            : EX/MEM taken branch and target
//   jump, jump_destination             : ID jump and target
//   imem_req, imem_addr                : fetch request and address (= pc)
//   imem_ready, imem_rdata             : fetch response handshake and data
//   IF_ID_IR, IF_ID_NPC, IF_ID_valid   : IF/ID pipeline register
//   flush_id                           : one-cycle kill of the instruction in ID
//   pc                                 : current PC
module if_fetch_controller
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INSN = NOP_INSN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch,
  input  logic [ADDR_W-1:0] EXMEM_AddResult,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_destination,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       IF_ID_IR,
  output logic [ADDR_W-1:0] IF_ID_NPC,
  output logic              IF_ID_valid,
  output logic              flush_id,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_tgt;
  logic              redir;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  if_redirect_sel #(.ADDR_W(ADDR_W)) u_redirect_sel (
    .branch        (branch),
    .branch_target (EXMEM_AddResult),
    .jump          (jump),
    .jump_target   (jump_destination),
    .redir         (redir),
    .target        (target)
  );

  assign pc_inc    = pc + ADDR_W'(1);
  assign imem_addr = pc;
  assign imem_req  = rst_n && (state != S_STALL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      IF_ID_IR    <= NOP_INSN;
      IF_ID_NPC   <= '0;
      IF_ID_valid <= 1'b0;
      flush_id    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_tgt    <= '0;
    end else begin
      flush_id <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            if (redir) begin
              pc          <= target;
              IF_ID_IR    <= NOP_INSN;
              IF_ID_valid <= 1'b0;
              flush_id    <= 1'b1;
            end else if (stall) begin
              // The returned word is dropped; the same pc is refetched after the stall.
              state <= S_STALL;
            end else begin
              IF_ID_IR    <= imem_rdata;
              IF_ID_NPC   <= pc_inc;
              IF_ID_valid <= 1'b1;
              pc          <= pc_inc;
            end
          end else begin
            state <= S_WAIT;
            // The access to pc must complete before pc can move, so the redirect is parked.
            if (redir) begin
              pend_valid <= 1'b1;
              pend_tgt   <= target;
              flush_id   <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (!imem_ready) begin
            if (redir) begin
              pend_valid <= 1'b1;
              pend_tgt   <= target;
              flush_id   <= 1'b1;
            end
          end else begin
            pend_valid <= 1'b0;
            state      <= S_FETCH;
            if (redir) begin
              pc          <= target;
              IF_ID_IR    <= NOP_INSN;
              IF_ID_valid <= 1'b0;
              flush_id    <= 1'b1;
            end else if (pend_valid) begin
              // flush_id for this redirect already fired when it was parked.
              pc          <= pend_tgt;
              IF_ID_IR    <= NOP_INSN;
              IF_ID_valid <= 1'b0;
            end else if (stall) begin
              state <= S_STALL;
            end else begin
              IF_ID_IR    <= imem_rdata;
              IF_ID_NPC   <= pc_inc;
              IF_ID_valid <= 1'b1;
              pc          <= pc_inc;
            end
          end
        end

        S_STALL: begin
          if (redir) begin
            pc          <= target;
            IF_ID_IR    <= NOP_INSN;
            IF_ID_valid <= 1'b0;
            flush_id    <= 1'b1;
            state       <= S_FETCH;
          end else if (!stall) begin
            state <= S_FETCH;
          end
        end

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_controller.sv
// tb/tb_if_fetch_controller.sv - scoreboard bench for if_fetch_controller
module tb_if_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] EXMEM_AddResult = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_destination = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_IR;
  logic [31:0] IF_ID_NPC;
  logic        IF_ID_valid;
  logic        flush_id;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'h5A, a[23:0]} ^ {a[31:24], 24'h0};
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  if_fetch_controller #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INSN (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .branch           (branch),
    .EXMEM_AddResult  (EXMEM_AddResult),
    .jump             (jump),
    .jump_destination (jump_destination),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .IF_ID_IR         (IF_ID_IR),
    .IF_ID_NPC        (IF_ID_NPC),
    .IF_ID_valid      (IF_ID_valid),
    .flush_id         (flush_id),
    .pc               (pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] npc;
    logic        valid;
    logic        flush;
    logic        req;
  } exp_t;

  exp_t sb[$];

  // Reference model: a fetch is an outstanding request that is answered when ready=1.
  // A redirect seen while unanswered is remembered and applied when the answer comes;
  // a stall seen on an answer drops it and idles until stall clears or a redirect arrives.
  logic [31:0] m_pc, m_ir, m_npc;
  logic        m_valid, m_flush;
  logic        m_held;
  logic        m_have_pend;
  logic [31:0] m_pend;

  task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] bt,
                            input bit j, input logic [31:0] jt, input bit rdy);
    bit          want;
    logic [31:0] dest;
    want = b || j;
    dest = b ? bt : jt;
    m_flush = 1'b0;
    if (!r) begin
      m_pc = 0; m_ir = 0; m_npc = 0; m_valid = 0;
      m_held = 0; m_have_pend = 0; m_pend = 0;
    end else if (m_held) begin
      if (want) begin
        m_pc = dest; m_ir = 0; m_valid = 0; m_flush = 1; m_held = 0;
      end else if (!s) begin
        m_held = 0;
      end
    end else if (!rdy) begin
      if (want) begin
        m_have_pend = 1; m_pend = dest; m_flush = 1;
      end
    end else begin
      if (want) begin
        m_pc = dest; m_ir = 0; m_valid = 0; m_flush = 1;
      end else if (m_have_pend) begin
        m_pc = m_pend; m_ir = 0; m_valid = 0;
      end else if (s) begin
        m_held = 1;
      end else begin
        m_ir = mem_word(m_pc); m_npc = m_pc + 1; m_valid = 1; m_pc = m_pc + 1;
      end
      m_have_pend = 0;
    end
  endtask

  exp_t pend_exp;
  bit   have_exp = 0;

  task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit rdy);
    @(posedge clk);
    #1;
    if (have_exp) begin
      pend_exp.req = r && !m_held;
      sb.push_back(pend_exp);
    end
    rst_n = r; stall = s; branch = b; EXMEM_AddResult = bt;
    jump = j; jump_destination = jt; imem_ready = rdy;
    model_step(r, s, b, bt, j, jt, rdy);
    pend_exp.pc    = m_pc;
    pend_exp.ir    = m_ir;
    pend_exp.npc   = m_npc;
    pend_exp.valid = m_valid;
    pend_exp.flush = m_flush;
    pend_exp.req   = 1'b0;
    have_exp = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc",          pc,                   e.pc);
        chk("IF_ID_IR",    IF_ID_IR,             e.ir);
        chk("IF_ID_NPC",   IF_ID_NPC,            e.npc);
        chk("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, e.valid});
        chk("flush_id",    {31'b0, flush_id},    {31'b0, e.flush});
        chk("imem_req",    {31'b0, imem_req},    {31'b0, e.req});
        chk("imem_addr",   imem_addr,            e.pc);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    m_pc = 0; m_ir = 0; m_npc = 0; m_valid = 0; m_flush = 0;
    m_held = 0; m_have_pend = 0; m_pend = 0;

    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(5);                                           // pc reaches 5
    cycle(1, 0, 1, 32'h20, 0, 0, 1);                   // branch to 0x20
    idle(3);
    cycle(1, 0, 1, 32'h40, 1, 32'h80, 1);              // branch beats jump
    idle(2);
    cycle(1, 0, 0, 0, 1, 32'h7, 1);                    // move to pc=7
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 1);
    idle(2);
    cycle(1, 0, 0, 0, 0, 0, 0);                        // wait 4 cycles, jump in cycle 2
    cycle(1, 0, 0, 0, 1, 32'h10, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    cycle(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 1);            // wrap at top of address space
    idle(3);
    cycle(1, 0, 0, 0, 0, 0, 0);                        // reset in the middle of a wait
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    cycle(1, 1, 0, 0, 0, 0, 1);                        // stall then redirect out of stall
    cycle(1, 1, 0, 0, 1, 32'h33, 1);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      bit          r, s, b, j, rdy;
      logic [31:0] bt, jt;
      r   = ($urandom_range(0, 59) != 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 7) == 0);
      j   = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      bt  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      jt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 255));
      cycle(r, s, b, bt, j, jt, rdy);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
